// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared light encodings and latch FSM state type for the sensor conditioner
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } latch_state_e;

endpackage

// File: rtl/tl_sensor_cond_debounce_r.sv
// rtl/tl_sensor_cond_debounce_r.sv - 2-flop synchronizer plus counter debouncer for one sensor channel
module tl_sensor_cond_debounce_r #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized sample disagrees with the
    // accepted level; the step that would reach DEB_CYCLES flips the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/tl_sensor_cond.sv
// rtl/tl_sensor_cond.sv - debounced traffic-present outputs for two streets
// Define TL_SENSOR_LATCH_EN to hold each request until the debounced sensor is low under GREEN.
module tl_sensor_cond
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Sa_raw,
    input  logic       Sb_raw,
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    output logic       Ta,
    output logic       Tb
);

    logic deb_a, deb_b;
    logic ta_q, ta_d, tb_q, tb_d;

    tl_sensor_cond_debounce_r #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (Sa_raw),
        .level   (deb_a)
    );

    tl_sensor_cond_debounce_r #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (Sb_raw),
        .level   (deb_b)
    );

`ifdef TL_SENSOR_LATCH_EN
    latch_state_e state_a_q, state_a_d, state_b_q, state_b_d;

    // A request is only released once the car has gone and its street has been served.
    function automatic latch_state_e next_state(input latch_state_e s, input logic deb,
                                                input logic [1:0] light);
        latch_state_e n;
        n = s;
        case (s)
            IDLE:    if (deb) n = REQ;
            REQ:     if (!deb && (light == GREEN)) n = IDLE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    always_comb begin
        state_a_d = next_state(state_a_q, deb_a, La);
        state_b_d = next_state(state_b_q, deb_b, Lb);
        ta_d      = (state_a_d == REQ);
        tb_d      = (state_b_d == REQ);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_a_q <= IDLE;
            state_b_q <= IDLE;
        end else begin
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
        end
    end
`else
    logic unused_lights;
    assign unused_lights = ^{La, Lb};

    always_comb begin
        ta_d = deb_a;
        tb_d = deb_b;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ta_q <= 1'b0;
            tb_q <= 1'b0;
        end else begin
            ta_q <= ta_d;
            tb_q <= tb_d;
        end
    end

    assign Ta = ta_q;
    assign Tb = tb_q;

endmodule

// File: tb/tb_tl_sensor_cond.sv
// tb/tb_tl_sensor_cond.sv - self-checking bench for tl_sensor_cond with a history-window reference model
module tb_tl_sensor_cond;
    import tl_pkg::*;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       Sa_raw = 1'b0, Sb_raw = 1'b0;
    logic [1:0] La = RED, Lb = RED;
    logic       Ta, Tb;

    int total = 0;
    int bad = 0;

    // Reference model: raw samples per edge since reset, accepted levels, latch states.
    bit ha[$];
    bit hb[$];
    bit deb_a_m, deb_b_m, st_a_m, st_b_m, exp_ta, exp_tb;

    tl_sensor_cond #(.DEB_CYCLES(DEB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Sa_raw  (Sa_raw),
        .Sb_raw  (Sb_raw),
        .La      (La),
        .Lb      (Lb),
        .Ta      (Ta),
        .Tb      (Tb)
    );

    always #5 clk = ~clk;

    // The level flips at edge n when the DEB samples the synchronizer delivered
    // (raw sampled at edges n-2 .. n-1-DEB) all disagree with the current level.
    function automatic bit flips(input bit h[$], input bit deb);
        int n;
        bit v;
        n = h.size() - 1;
        for (int k = 2; k <= DEB + 1; k++) begin
            v = (n - k < 0) ? 1'b0 : h[n-k];
            if (v == deb) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit latch_next(input bit st, input bit deb, input logic [1:0] l);
        if (!st) return deb;
        return !(!deb && l == 2'b00);
    endfunction

    task automatic model_reset();
        ha.delete();
        hb.delete();
        deb_a_m = 0; deb_b_m = 0; st_a_m = 0; st_b_m = 0;
        exp_ta = 0; exp_tb = 0;
    endtask

    task automatic step();
        bit pa, pb;
        @(posedge clk);
        ha.push_back(Sa_raw);
        hb.push_back(Sb_raw);
        pa = deb_a_m;
        pb = deb_b_m;
        if (flips(ha, deb_a_m)) deb_a_m = !deb_a_m;
        if (flips(hb, deb_b_m)) deb_b_m = !deb_b_m;
`ifdef TL_SENSOR_LATCH_EN
        st_a_m = latch_next(st_a_m, pa, La);
        st_b_m = latch_next(st_b_m, pb, Lb);
        exp_ta = st_a_m;
        exp_tb = st_b_m;
`else
        exp_ta = pa;
        exp_tb = pb;
`endif
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Sa_raw = 1; Sb_raw = 1;
        #2;
        total++;
        if (Ta !== 1'b0 || Tb !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: Ta=%b Tb=%b required 0 0", Ta, Tb);
        end
        Sa_raw = 0; Sb_raw = 0;
        do_reset();
    endtask

    task automatic test_rise_fall();
        La = GREEN;
        Sa_raw = 1;
        for (int e = 0; e <= 6; e++) begin
            step();
            total++;
            if (Ta !== (e >= 6)) begin
                bad++;
                $display("FAIL rise_edge%0d: Ta=%b required %b", e, Ta, e >= 6);
            end
        end
        Sa_raw = 0;
        for (int e = 0; e <= 6; e++) begin
            step();
            total++;
            if (Ta !== (e < 6)) begin
                bad++;
                $display("FAIL fall_edge%0d: Ta=%b required %b", e, Ta, e < 6);
            end
        end
    endtask

    task automatic test_glitch();
        Sb_raw = 1;
        for (int e = 0; e < 12; e++) begin
            if (e == 3) Sb_raw = 0;
            step();
            total++;
            if (Tb !== 1'b0) begin
                bad++;
                $display("FAIL glitch_edge%0d: Tb=%b required 0", e, Tb);
            end
        end
        total++;
        if (dut.u_deb_b.cnt_q !== '0) begin
            bad++;
            $display("FAIL glitch_counter: cnt=%0d required 0", dut.u_deb_b.cnt_q);
        end
    endtask

    task automatic test_simultaneous();
        La = GREEN; Lb = GREEN;
        Sa_raw = 1; Sb_raw = 1;
        for (int e = 0; e <= 6; e++) begin
            step();
            total++;
            if (Ta !== (e >= 6) || Tb !== (e >= 6)) begin
                bad++;
                $display("FAIL both_edge%0d: Ta=%b Tb=%b required %b", e, Ta, Tb, e >= 6);
            end
        end
        Sa_raw = 0; Sb_raw = 0;
        repeat (8) step();
    endtask

`ifdef TL_SENSOR_LATCH_EN
    task automatic test_latch();
        do_reset();
        La = RED;
        Sa_raw = 1;
        repeat (10) step();
        Sa_raw = 0;
        for (int e = 0; e < 12; e++) begin
            step();
            total++;
            if (Ta !== (e >= 0 ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL latch_hold%0d: Ta=%b required 1", e, Ta);
            end
        end
        La = GREEN;
        step();
        total++;
        if (Ta !== 1'b0) begin
            bad++;
            $display("FAIL latch_release: Ta=%b required 0", Ta);
        end
        Sa_raw = 1;
        for (int e = 0; e < 14; e++) begin
            step();
            total++;
            if (Ta !== (e >= 6)) begin
                bad++;
                $display("FAIL latch_green_edge%0d: Ta=%b required %b", e, Ta, e >= 6);
            end
        end
        Sa_raw = 0;
        repeat (8) step();
    endtask
`endif

    task automatic test_reset_mid();
        La = GREEN;
        Sa_raw = 1;
        for (int e = 0; e <= 4; e++) step();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (Ta !== 1'b0 || dut.u_deb_a.cnt_q !== '0) begin
            bad++;
            $display("FAIL reset_mid_debounce: Ta=%b cnt=%0d required 0 0", Ta, dut.u_deb_a.cnt_q);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step();
            total++;
            if (Ta !== (e >= 6)) begin
                bad++;
                $display("FAIL restart_edge%0d: Ta=%b required %b", e, Ta, e >= 6);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (Ta !== 1'b0) begin
            bad++;
            $display("FAIL reset_while_high: Ta=%b required 0", Ta);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
            total++;
            if (Ta !== (e >= 6)) begin
                bad++;
                $display("FAIL restart2_edge%0d: Ta=%b required %b", e, Ta, e >= 6);
            end
        end
        Sa_raw = 0;
        do_reset();
    endtask

    task automatic test_random();
        int hold_a = 0, hold_b = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (hold_a == 0) begin
                Sa_raw = ~Sa_raw;
                hold_a = $urandom_range(1, 9);
            end
            if (hold_b == 0) begin
                Sb_raw = ~Sb_raw;
                hold_b = $urandom_range(1, 9);
            end
            hold_a--;
            hold_b--;
            La = 2'($urandom_range(0, 3));
            Lb = 2'($urandom_range(0, 3));
            step();
            total++;
            if (Ta !== exp_ta || Tb !== exp_tb) begin
                bad++;
                $display("FAIL random_cycle%0d: Ta=%b Tb=%b required %b %b", c, Ta, Tb, exp_ta, exp_tb);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rise_fall();
        test_glitch();
        test_simultaneous();
`ifdef TL_SENSOR_LATCH_EN
        test_latch();
`endif
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
